// File: rtl/multiplier_iter.sv
// multiplier_iter: iterative shift-add multiplier, one product per WIDTH+2 cycles.
// Operands are converted to magnitudes on acceptance. WIDTH add/shift steps
// build the unsigned product, and the sign is applied when the result is
// written to the output register.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready high only in IDLE)
//   a, b                WIDTH-bit multiplicand / multiplier
//   signed_mode         1 = two's complement operands and result
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   product             2*WIDTH-bit result register, held until next completion
//   busy                high while CALC or DONE
module multiplier_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [PW-1:0]     acc_sum;

  // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  // The multiplicand shifts left and the multiplier shifts right each step.
  // This keeps the partial-product select at bit 0 with no variable shifter.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = PW'(a_mag);
          mplier_d = b_mag;
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = sign_q ? -acc_sum : acc_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_multiplier_iter.sv
// Self-checking bench for multiplier_iter (WIDTH=8).
// A cycle-level behavioural model computes products with native arithmetic.
// A negedge compare process checks every output against that model.
// Directed operations additionally check hand-computed literal products.
module tb_multiplier_iter;
  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] product;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multiplier_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint xi, yi;
    if (s) begin
      xi = longint'($signed(x));
      yi = longint'($signed(y));
    end else begin
      xi = longint'(x);
      yi = longint'(y);
    end
    return PW'(xi * yi);
  endfunction

  // Behavioural model: a pending product appears W edges after acceptance.
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  int            m_cnt = 0;
  int            m_done = 0;
  logic [PW-1:0] m_prod = '0;
  logic [PW-1:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_prod  <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= W;
        m_pend <= ref_mul(a, b, signed_mode);
      end
    end else if (!m_valid) begin
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_prod  <= m_pend;
        m_done  <= m_done + 1;
      end
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready",  64'(in_ready),  64'(!m_busy));
    check("busy",      64'(busy),      64'(m_busy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("product",   64'(product),   64'(m_prod));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [PW-1:0] exp, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    a = x; b = y; signed_mode = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 4 * W) begin step(); n++; end
    check({name, "_latency"}, 64'(n), 64'(W));
    check(name, 64'(product), 64'(exp));
  endtask

  initial begin
    // Reset, then a reset that lands mid-CALC.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_product", 64'(product), 64'd0);
    a = 8'd200; b = 8'd3; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("midcalc_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_product", 64'(product), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);
    repeat (12) step();
    check("no_stale_valid", 64'(out_valid), 64'd0);

    // Unsigned directed vectors.
    out_ready = 1'b1;
    do_op(8'd1,   8'd255, 1'b0, 16'd255,   "u_1x255");
    do_op(8'd5,   8'd10,  1'b0, 16'd50,    "u_5x10");
    do_op(8'd15,  8'd15,  1'b0, 16'd225,   "u_15x15");
    do_op(8'd127, 8'd2,   1'b0, 16'd254,   "u_127x2");
    do_op(8'd255, 8'd255, 1'b0, 16'hFE01,  "u_255x255");

    // Signed directed vectors.
    do_op(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1");
    do_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    do_op(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127");
    do_op(8'h00, 8'hFB, 1'b1, 16'h0000, "s_0xm5");
    do_op(8'hFD, 8'h07, 1'b1, 16'hFFEB, "s_m3x7");

    // Back-pressure: DONE holds and new operands are ignored.
    step();
    out_ready = 1'b0;
    a = 8'd9; b = 8'd11; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 4 * W) begin step(); n++; end
    end
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = i[0];
      signed_mode = 1'($urandom);
      step();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_product", 64'(product), 64'h0063);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
    check("hs_product_held", 64'(product), 64'h0063);

    // Operand isolation: inputs churn during CALC.
    a = 8'd100; b = 8'hFE; signed_mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 4 * W) begin
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
        step();
        n++;
      end
      check("iso_latency", 64'(n), 64'(W));
    end
    check("iso_product", 64'(product), 64'hFF38);
    step();

    // Random traffic with output stalls, per mode.
    for (int mode = 0; mode < 2; mode++) begin
      int start_done;
      start_done = m_done;
      signed_mode = 1'(mode);
      for (int c = 0; c < 3000; c++) begin
        a = W'($urandom); b = W'($urandom);
        in_valid = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      check("rand_results", 64'(m_done - start_done > 100), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2 * W + 4) step();
    check("drain_idle", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
